// File: rtl/alu_issue_ctrl_if.sv
// Instruction issue channel into alu_issue_ctrl: one decoded ALU op plus its
// B operand, transferred on a valid/ready handshake.
interface alu_issue_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             instr_valid;
    logic             instr_ready;
    logic [3:0]       instr_op;
    logic [WIDTH-1:0] instr_operand;

    modport master (
        output instr_valid,
        output instr_op,
        output instr_operand,
        input  instr_ready
    );

    modport slave (
        input  instr_valid,
        input  instr_op,
        input  instr_operand,
        output instr_ready
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue/write-back stage in front of the ALU: owns AC and Z, issues one op at a
// time to the ALU and captures its result after a fixed latency.
module alu_issue_ctrl #(
    parameter int ALU_LATENCY = 4,
    parameter int WIDTH       = 16
) (
    input  logic             clk,
    input  logic             reset,
    alu_issue_ctrl_if.slave  instr,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_op,
    output logic             alu_enable,
    input  logic [WIDTH-1:0] alu_c,
    input  logic             alu_z,
    output logic [WIDTH-1:0] ac_out,
    output logic             z_out,
    output logic             busy,
    output logic             done,
    output logic             err
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] LAT_M1 = 4'(ALU_LATENCY - 1);

    state_t     state;
    logic [3:0] wait_cnt;
    logic       accept;

    function automatic logic op_legal(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd11);
    endfunction

    assign busy              = (state != IDLE);
    assign instr.instr_ready = ~busy;
    assign accept            = instr.instr_valid && ~busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            ac_out     <= '0;
            z_out      <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            alu_enable <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done       <= 1'b0;
            err        <= 1'b0;
            alu_enable <= 1'b0;
            case (state)
                IDLE: begin
                    // ALU buses are loaded at accept so they are already valid in the ISSUE cycle
                    if (accept) begin
                        if (op_legal(instr.instr_op)) begin
                            alu_a      <= ac_out;
                            alu_b      <= instr.instr_operand;
                            alu_op     <= instr.instr_op;
                            alu_enable <= 1'b1;
                            state      <= ISSUE;
                        end else begin
                            done <= 1'b1;
                            err  <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    wait_cnt <= LAT_M1;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        ac_out <= alu_c;
                        // Only a subtract defines the zero flag for branches
                        if (alu_op == OP_SUB) begin
                            z_out <= alu_z;
                        end
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: two instances (latency 4 and 1) driven
// with directed instructions; a negedge monitor pops and checks each retire.
module tb_alu_issue_ctrl;
    logic clk;
    logic reset;

    alu_issue_ctrl_if #(.WIDTH(16)) bus0 ();
    alu_issue_ctrl_if #(.WIDTH(16)) bus1 ();

    logic [15:0] alu_a0, alu_b0, alu_c0, ac0;
    logic [3:0]  alu_op0;
    logic        alu_en0, alu_z0, z0, busy0, done0, err0;
    logic [15:0] alu_a1, alu_b1, alu_c1, ac1;
    logic [3:0]  alu_op1;
    logic        alu_en1, alu_z1, z1, busy1, done1, err1;

    alu_issue_ctrl #(.ALU_LATENCY(4), .WIDTH(16)) dut0 (
        .clk(clk), .reset(reset), .instr(bus0),
        .alu_a(alu_a0), .alu_b(alu_b0), .alu_op(alu_op0), .alu_enable(alu_en0),
        .alu_c(alu_c0), .alu_z(alu_z0), .ac_out(ac0), .z_out(z0),
        .busy(busy0), .done(done0), .err(err0)
    );

    alu_issue_ctrl #(.ALU_LATENCY(1), .WIDTH(16)) dut1 (
        .clk(clk), .reset(reset), .instr(bus1),
        .alu_a(alu_a1), .alu_b(alu_b1), .alu_op(alu_op1), .alu_enable(alu_en1),
        .alu_c(alu_c1), .alu_z(alu_z1), .ac_out(ac1), .z_out(z1),
        .busy(busy1), .done(done1), .err(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: result is a pure function of the held A/B/op buses
    function automatic logic [16:0] alu_model(input logic [3:0] op, input logic [15:0] a,
                                              input logic [15:0] b);
        logic [15:0] c;
        case (op)
            4'd1:    c = a + b;
            4'd2:    c = a - b;
            4'd3:    c = a;
            4'd4:    c = b;
            4'd5:    c = a + 16'd1;
            4'd6:    c = a - 16'd1;
            4'd7:    c = a << 1;
            4'd8:    c = a << 2;
            4'd9:    c = a << 8;
            4'd10:   c = a >> 4;
            default: c = 16'd0;
        endcase
        return {(c == 16'd0), c};
    endfunction

    assign {alu_z0, alu_c0} = alu_model(alu_op0, alu_a0, alu_b0);
    assign {alu_z1, alu_c1} = alu_model(alu_op1, alu_a1, alu_b1);

    typedef struct {
        logic [3:0]  op;
        logic [15:0] operand;
        logic [15:0] exp_a;
        logic [15:0] exp_ac;
        logic        exp_z;
        logic        exp_err;
        int          exp_lat;
        int          exp_en;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int   checks = 0;
    int   errors = 0;
    logic acc_prev[2];
    int   cyc[2];
    int   acc_cyc[2];
    int   en_cnt[2];
    logic acc_with_done;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic mon_step(input int id, input logic rst_s, input logic valid_s,
                            input logic ready_s, input logic en_s, input logic done_s,
                            input logic err_s, input logic z_s, input logic [15:0] ac_s,
                            input logic [15:0] a_s, input logic [15:0] b_s,
                            input logic [3:0] op_s);
        exp_t e;
        bit   have;
        cyc[id]++;
        if (rst_s) begin
            acc_prev[id] = 1'b0;
            return;
        end
        if (acc_prev[id]) begin
            acc_cyc[id] = cyc[id];
            en_cnt[id]  = 0;
        end
        have = (id == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (have) begin
            if (id == 0) e = q0[0];
            else         e = q1[0];
        end
        if (en_s) begin
            en_cnt[id]++;
            if (have) begin
                chk($sformatf("d%0d_en_timing", id), 64'(cyc[id] - acc_cyc[id]), 64'd0);
                chk($sformatf("d%0d_issue_bus", id), {a_s, b_s, op_s}, {e.exp_a, e.operand, e.op});
            end
        end
        if (done_s) begin
            if (!have) begin
                checks++;
                errors++;
                $display("FAIL d%0d_unexpected_done actual=1 required=0", id);
            end else begin
                if (id == 0) e = q0.pop_front();
                else         e = q1.pop_front();
                chk($sformatf("d%0d_ac op%0d", id, e.op), ac_s, e.exp_ac);
                chk($sformatf("d%0d_z op%0d", id, e.op), z_s, e.exp_z);
                chk($sformatf("d%0d_err op%0d", id, e.op), err_s, e.exp_err);
                chk($sformatf("d%0d_latency op%0d", id, e.op), 64'(cyc[id] - acc_cyc[id] + 1),
                    64'(e.exp_lat));
                chk($sformatf("d%0d_en_count op%0d", id, e.op), 64'(en_cnt[id]), 64'(e.exp_en));
            end
        end
        acc_prev[id] = valid_s && ready_s;
    endtask

    always @(negedge clk) begin
        mon_step(0, reset, bus0.instr_valid, bus0.instr_ready, alu_en0, done0, err0, z0, ac0,
                 alu_a0, alu_b0, alu_op0);
        mon_step(1, reset, bus1.instr_valid, bus1.instr_ready, alu_en1, done1, err1, z1, ac1,
                 alu_a1, alu_b1, alu_op1);
    end

    task automatic drive(input int id, input logic v, input logic [3:0] op, input logic [15:0] opd);
        if (id == 0) begin
            bus0.instr_valid = v; bus0.instr_op = op; bus0.instr_operand = opd;
        end else begin
            bus1.instr_valid = v; bus1.instr_op = op; bus1.instr_operand = opd;
        end
    endtask

    task automatic send(input int id, input logic [3:0] op, input logic [15:0] opd,
                        input logic [15:0] exp_a, input logic [15:0] exp_ac,
                        input logic exp_z, input bit push);
        exp_t e;
        bit   legal;
        bit   accepted;
        legal     = (op >= 4'd1) && (op <= 4'd11);
        e.op      = op;
        e.operand = opd;
        e.exp_a   = exp_a;
        e.exp_ac  = exp_ac;
        e.exp_z   = exp_z;
        e.exp_err = !legal;
        e.exp_lat = legal ? ((id == 0) ? 6 : 3) : 1;
        e.exp_en  = legal ? 1 : 0;
        if (push) begin
            if (id == 0) q0.push_back(e);
            else         q1.push_back(e);
        end
        drive(id, 1'b1, op, opd);
        accepted = 0;
        for (int i = 0; i < 40; i++) begin
            if ((id == 0) ? bus0.instr_ready : bus1.instr_ready) begin
                acc_with_done = (id == 0) ? done0 : done1;
                @(posedge clk); #2;
                accepted = 1;
                break;
            end
            @(posedge clk); #2;
        end
        if (!accepted) begin
            checks++;
            errors++;
            $display("FAIL d%0d_accept_timeout actual=0 required=1", id);
        end
    endtask

    task automatic drain(input int id);
        bit idle;
        idle = 0;
        for (int i = 0; i < 40; i++) begin
            if (((id == 0) ? q0.size() : q1.size()) == 0 && !((id == 0) ? busy0 : busy1)) begin
                idle = 1;
                break;
            end
            @(posedge clk); #2;
        end
        if (!idle) begin
            checks++;
            errors++;
            $display("FAIL d%0d_retire_timeout actual=pending required=empty", id);
        end
    endtask

    task automatic one(input int id, input logic [3:0] op, input logic [15:0] opd,
                       input logic [15:0] exp_a, input logic [15:0] exp_ac, input logic exp_z);
        send(id, op, opd, exp_a, exp_ac, exp_z, 1'b1);
        drive(id, 1'b0, 4'd0, 16'd0);
        drain(id);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            acc_prev[i] = 0; cyc[i] = 0; acc_cyc[i] = 0; en_cnt[i] = 0;
        end
        acc_with_done = 1'b0;
        reset = 1'b1;
        drive(0, 1'b0, 4'd0, 16'd0);
        drive(1, 1'b0, 4'd0, 16'd0);
        repeat (2) @(posedge clk);
        #2;
        chk("rst_ctrl", {busy0, bus0.instr_ready, done0, err0, alu_en0, z0}, 6'b010000);
        chk("rst_ac", ac0, 16'h0000);
        chk("rst_alu_bus", {alu_a0, alu_b0, alu_op0}, 36'h0);
        reset = 1'b0;
        @(posedge clk); #2;

        // ADD, SUB to zero, then INCAC leaves Z set
        one(0, 4'd1, 16'h0005, 16'h0000, 16'h0005, 1'b0);
        one(0, 4'd2, 16'h0005, 16'h0005, 16'h0000, 1'b1);
        one(0, 4'd5, 16'h0000, 16'h0000, 16'h0001, 1'b1);
        one(0, 4'd4, 16'h0012, 16'h0001, 16'h0012, 1'b1);

        // Back-to-back with valid held: second accept lands in the done cycle
        send(0, 4'd9, 16'h0000, 16'h0012, 16'h1200, 1'b1, 1'b1);
        send(0, 4'd10, 16'h0000, 16'h1200, 16'h0120, 1'b1, 1'b1);
        chk("b2b_accept_in_done_cycle", acc_with_done, 1'b1);
        drive(0, 1'b0, 4'd0, 16'd0);
        drain(0);

        // Illegal opcodes retire immediately with err and leave AC/Z alone
        one(0, 4'hE, 16'hFFFF, 16'h0000, 16'h0120, 1'b1);
        one(0, 4'h0, 16'h1234, 16'h0000, 16'h0120, 1'b1);

        // Reset in the middle of WAIT drops the instruction
        send(0, 4'd1, 16'h0007, 16'h0120, 16'h0127, 1'b1, 1'b0);
        drive(0, 1'b0, 4'd0, 16'd0);
        repeat (2) begin @(posedge clk); #2; end
        chk("busy_in_wait", busy0, 1'b1);
        reset = 1'b1;
        #1;
        chk("midrst_ctrl", {busy0, bus0.instr_ready, done0, err0, alu_en0, z0}, 6'b010000);
        chk("midrst_ac", ac0, 16'h0000);
        repeat (2) begin @(posedge clk); #2; end
        reset = 1'b0;
        repeat (8) begin @(posedge clk); #2; end

        one(0, 4'd1, 16'h0003, 16'h0000, 16'h0003, 1'b0);
        one(0, 4'd11, 16'h5555, 16'h0003, 16'h0000, 1'b0);
        one(0, 4'd2, 16'h0001, 16'h0000, 16'hFFFF, 1'b0);

        // Minimum-latency instance
        one(1, 4'd4, 16'hBEEF, 16'h0000, 16'hBEEF, 1'b0);
        one(1, 4'd6, 16'h0000, 16'hBEEF, 16'hBEEE, 1'b0);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
